// File: rtl/dma_stream_arbiter.sv
// Priority + round-robin arbiter giving one DMA stream the shared AHB master port per transaction.
// Optional watchdog release is compiled in with `define DMA_ARB_TIMEOUT_EN.
module dma_stream_arbiter #(
    parameter int numb_streams   = 8,
    parameter int size_addr      = $clog2(numb_streams),
    parameter int timeout_cycles = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [numb_streams-1:0]   i_req,
    input  logic [2*numb_streams-1:0] i_prio,
    input  logic                      i_done,
    output logic                      o_gnt_valid,
    output logic [size_addr-1:0]      o_gnt_addr,
    output logic                      o_busy,
    output logic                      o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    if (numb_streams < 2) begin : g_bad_streams
        $error("dma_stream_arbiter: numb_streams must be at least 2");
    end
    if (timeout_cycles < 2) begin : g_bad_timeout
        $error("dma_stream_arbiter: timeout_cycles must be at least 2");
    end

    state_e                  state_q, state_d;
    logic [size_addr-1:0]    gnt_addr_q, gnt_addr_d;
    logic [size_addr-1:0]    rr_ptr_q, rr_ptr_d;
    logic                    gnt_valid_q, gnt_valid_d;
    logic                    timeout_q, timeout_d;

    logic [1:0]              max_prio;
    logic [numb_streams-1:0] eligible;
    logic [size_addr-1:0]    winner;
    logic                    any_req;
    logic                    wd_expire;

    assign any_req = |i_req;

    always_comb begin
        max_prio = 2'd0;
        for (int k = 0; k < numb_streams; k++) begin
            if (i_req[k] && (i_prio[2*k +: 2] > max_prio)) begin
                max_prio = i_prio[2*k +: 2];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < numb_streams; gi++) begin : g_elig
            assign eligible[gi] = i_req[gi] && (i_prio[2*gi +: 2] == max_prio);
        end
    endgenerate

    // Scan from the far end towards rr_ptr+1 so the closest eligible stream is written last.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int off = numb_streams; off >= 1; off--) begin
            idx = (int'(rr_ptr_q) + off) % numb_streams;
            if (eligible[idx]) begin
                winner = size_addr'(idx);
            end
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_cycles + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_expire = (state_q == ST_GRANT) && (wd_cnt_q == CNT_W'(timeout_cycles - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_IDLE) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_GRANT && !wd_expire) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_addr_d  = gnt_addr_q;
        gnt_valid_d = gnt_valid_q;
        rr_ptr_d    = rr_ptr_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_addr_d  = winner;
                    gnt_valid_d = 1'b1;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A completion that coincides with expiry is a normal release.
                if (i_done || wd_expire) begin
                    gnt_valid_d = 1'b0;
                    rr_ptr_d    = gnt_addr_q;
                    timeout_d   = !i_done;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            gnt_addr_q  <= '0;
            gnt_valid_q <= 1'b0;
            rr_ptr_q    <= size_addr'(numb_streams - 1);
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_addr_q  <= gnt_addr_d;
            gnt_valid_q <= gnt_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_gnt_valid = gnt_valid_q;
    assign o_gnt_addr  = gnt_addr_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// Self-checking bench for dma_stream_arbiter: directed scenarios plus randomized grants
// checked against a priority-then-round-robin reference model.
module tb_dma_stream_arbiter;

    localparam int N   = 8;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [15:0] prio;
    logic        done;
    logic        gnt_valid;
    logic [2:0]  gnt_addr;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    int model_rr = N - 1;

    always #5 clk = ~clk;

    dma_stream_arbiter #(
        .numb_streams   (N),
        .size_addr      (3),
        .timeout_cycles (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_prio      (prio),
        .i_done      (done),
        .o_gnt_valid (gnt_valid),
        .o_gnt_addr  (gnt_addr),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    // Highest priority level first; within a level, nearest stream after the last winner.
    function automatic int model_winner(logic [7:0] r, logic [15:0] p, int rr);
        int  res;
        bit  found;
        int  idx;
        res   = -1;
        found = 1'b0;
        for (int lvl = 3; lvl >= 0; lvl--) begin
            for (int off = 1; off <= N; off++) begin
                idx = (rr + off) % N;
                if (!found && r[idx] && (int'(p[2*idx +: 2]) == lvl)) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (gnt_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        req  = '0;
        prio = '0;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_rr = N - 1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (gnt_valid !== 1'b0 || gnt_addr !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b addr=%0d busy=%b timeout=%b, expected all 0",
                     gnt_valid, gnt_addr, busy, timeout);
        end
    endtask

    task automatic test_basic();
        logic [2:0] ea;
        apply_reset();
        req  = 8'h24;
        prio = 16'h0000;
        ea   = 3'(model_winner(req, prio, model_rr));
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_grant: valid=%b addr=%0d busy=%b, expected valid=1 addr=2 busy=1",
                     gnt_valid, gnt_addr, busy);
        end
        total++;
        if (gnt_addr !== ea) begin
            bad++;
            $display("FAIL basic_model: addr=%0d, expected %0d", gnt_addr, ea);
        end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        model_rr = int'(ea);
        total++;
        if (gnt_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_release: valid=%b busy=%b, expected valid=0 busy=1", gnt_valid, busy);
        end
        tick();
        total++;
        if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: valid=%b busy=%b, expected valid=0 busy=0", gnt_valid, busy);
        end
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd5) begin
            bad++;
            $display("FAIL basic_next: valid=%b addr=%0d, expected valid=1 addr=5", gnt_valid, gnt_addr);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
    endtask

    task automatic test_round_robin();
        bit         ok;
        logic [1:0] lvl;
        apply_reset();
        lvl  = 2'($urandom_range(0, 3));
        req  = 8'hFF;
        prio = {8{lvl}};
        for (int g = 0; g < 9; g++) begin
            wait_valid(ok);
            total++;
            if (!ok || gnt_addr !== 3'(g % N)) begin
                bad++;
                $display("FAIL rr_order[%0d]: valid=%b addr=%0d, expected addr=%0d", g, ok, gnt_addr, g % N);
            end
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req = '0;
    endtask

    task automatic test_priority();
        bit ok;
        apply_reset();
        req  = 8'h81;
        prio = 16'hC001;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd7) begin
            bad++;
            $display("FAIL prio_win: valid=%b addr=%0d, expected valid=1 addr=7", gnt_valid, gnt_addr);
        end
        prio = 16'hC003;
        tick();
        tick();
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd7) begin
            bad++;
            $display("FAIL prio_no_preempt: valid=%b addr=%0d, expected valid=1 addr=7", gnt_valid, gnt_addr);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_valid(ok);
        total++;
        if (!ok || gnt_addr !== 3'd0) begin
            bad++;
            $display("FAIL prio_after: valid=%b addr=%0d, expected valid=1 addr=0", ok, gnt_addr);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
    endtask

    task automatic test_done_ignored();
        apply_reset();
        req = 8'h08;
        tick();
        req = 8'h00;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd3) begin
            bad++;
            $display("FAIL hold_after_drop: valid=%b addr=%0d, expected valid=1 addr=3", gnt_valid, gnt_addr);
        end
        done = 1'b1;
        tick();
        total++;
        if (gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_release: valid=%b, expected 0", gnt_valid);
        end
        tick();
        done = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_idle: busy=%b valid=%b, expected busy=0 valid=0", busy, gnt_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL done_in_idle: busy=%b, expected 0", busy);
        end
        req = 8'h08;
        tick();
        req = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd3) begin
            bad++;
            $display("FAIL regrant_held: valid=%b addr=%0d, expected valid=1 addr=3", gnt_valid, gnt_addr);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 8'h10;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd4) begin
            bad++;
            $display("FAIL rstmid_grant: valid=%b addr=%0d, expected valid=1 addr=4", gnt_valid, gnt_addr);
        end
        tick();
        rst  = 1'b1;
        done = 1'b1;
        tick();
        rst  = 1'b0;
        done = 1'b0;
        req  = 8'h30;
        total++;
        if (gnt_valid !== 1'b0 || gnt_addr !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_outputs: valid=%b addr=%0d busy=%b timeout=%b, expected all 0",
                     gnt_valid, gnt_addr, busy, timeout);
        end
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_addr !== 3'd4) begin
            bad++;
            $display("FAIL rstmid_regrant: valid=%b addr=%0d, expected valid=1 addr=4", gnt_valid, gnt_addr);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
    endtask

    task automatic test_random();
        bit          ok;
        int          exp;
        int          hold;
        logic [7:0]  r;
        logic [15:0] p;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            r    = 8'($urandom_range(1, 255));
            p    = 16'($urandom);
            req  = r;
            prio = p;
            exp  = model_winner(r, p, model_rr);
            wait_valid(ok);
            $display("txn %0d: req=%h prio=%h expected=%0d granted=%0d", t, r, p, exp, gnt_addr);
            total++;
            if (!ok || gnt_addr !== 3'(exp)) begin
                bad++;
                $display("FAIL rand_grant[%0d]: valid=%b addr=%0d, expected addr=%0d", t, ok, gnt_addr, exp);
            end
            hold = $urandom_range(0, 5);
            for (int h = 0; h < hold; h++) begin
                req  = 8'($urandom);
                prio = 16'($urandom);
                tick();
            end
            total++;
            if (gnt_valid !== 1'b1 || gnt_addr !== 3'(exp)) begin
                bad++;
                $display("FAIL rand_hold[%0d]: valid=%b addr=%0d, expected valid=1 addr=%0d",
                         t, gnt_valid, gnt_addr, exp);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            model_rr = exp;
        end
        req = '0;
    endtask

    task automatic test_watchdog();
        int high_cnt;
        int tmo_cnt;
        bit tmo_at_fall;
        bit fell;
        bit ok;
        apply_reset();
        req = 8'h01;
        tick();
        high_cnt    = (gnt_valid === 1'b1) ? 1 : 0;
        tmo_cnt     = 0;
        tmo_at_fall = 1'b0;
        fell        = 1'b0;
        for (int i = 0; i < 200 && !fell; i++) begin
            tick();
            if (timeout === 1'b1) tmo_cnt++;
            if (gnt_valid === 1'b1) begin
                high_cnt++;
            end else begin
                fell        = 1'b1;
                tmo_at_fall = (timeout === 1'b1);
            end
        end
        tick();
        tick();
        if (timeout === 1'b1) tmo_cnt++;
`ifdef DMA_ARB_TIMEOUT_EN
        total++;
        if (high_cnt != TMO || tmo_cnt != 1 || !tmo_at_fall) begin
            bad++;
            $display("FAIL wd_release: high=%0d pulses=%0d at_fall=%b, expected high=%0d pulses=1 at_fall=1",
                     high_cnt, tmo_cnt, tmo_at_fall, TMO);
        end
        req = 8'h03;
        wait_valid(ok);
        total++;
        if (!ok || gnt_addr !== 3'd1) begin
            bad++;
            $display("FAIL wd_rr_update: valid=%b addr=%0d, expected valid=1 addr=1", ok, gnt_addr);
        end
        req = 8'h00;
        for (int i = 0; i < TMO - 1; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL wd_done_same_cycle: valid=%b timeout=%b, expected valid=0 timeout=0",
                     gnt_valid, timeout);
        end
`else
        total++;
        if (high_cnt < 100 || fell || tmo_cnt != 0) begin
            bad++;
            $display("FAIL no_wd_persist: high=%0d fell=%b pulses=%0d, expected high>=100 fell=0 pulses=0",
                     high_cnt, fell, tmo_cnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        wait_valid(ok);
        total++;
        if (ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL no_wd_release: valid_seen=%b busy=%b, expected valid_seen=0 busy=0", ok, busy);
        end
`endif
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        prio = '0;
        done = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_priority();
        test_done_ignored();
        test_reset_mid();
        test_random();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
